ahb_sram_slave: RTL and testbench
=================================

// Module: ahb_sram_slave
// PURPOSE
//  AHB responder backed by a word-addressed on-chip SRAM. Sits behind the address decoder (hsel_N) and feeds
//  multiplexer_slave (hrdata_N/hreadyout_N/hresp_N). Implements the pipelined address/data phase,
//  programmable wait states, little-endian byte/halfword/word access and a two-cycle ERROR response.
// PARAMETERS
//  AW          10   log2 of memory depth in 32-bit words (window = 4*2**AW bytes from offset 0)
//  WAIT_STATES 0    hreadyout-low cycles inserted before completing each OKAY data phase (0..15)
// PORTS
//  hclk       in   1   bus clock, all state on rising edge
//  hreset     in   1   asynchronous, active-high reset
//  hsel       in   1   slave select from address decoder
//  haddr      in   32  byte address; only haddr[AW+1:0] used, bits above must be 0 else ERROR
//  htrans     in   2   IDLE=00 BUSY=01 NONSEQ=10 SEQ=11
//  hwrite     in   1   1=write, 0=read
//  hsize      in   3   0=byte 1=half 2=word; >2 -> ERROR
//  hburst     in   3   ignored (each beat checked independently)
//  hprot      in   4   ignored
//  hready     in   1   bus-level ready from multiplexer_slave
//  hwdata     in   32  write data, valid in data phase
//  hreadyout  out  1   this slave's ready
//  hresp      out  2   OKAY=00 ERROR=01 (RETRY/SPLIT never driven)
//  hrdata     out  32  read data, valid when hreadyout=1 in read data phase
// BEHAVIOUR
//  - Reset (async): state=IDLE, hreadyout=1, hresp=OKAY, hrdata=0, wait counter=0; SRAM contents not reset.
//  - Address phase accepted on edge where hsel & hready & htrans[1]; latch addr,size,write,lane strobes.
//    hsel with IDLE/BUSY, or !hsel: no data phase, next cycle hreadyout=1 hresp=OKAY.
//  - Error check at acceptance: hsize>2, half with haddr[0]=1, word with haddr[1:0]!=0, addr beyond window.
//  - FSM: IDLE -> DATA (good beat) | ERR1 (bad beat).
//    DATA: counter=WAIT_STATES; counter>0 -> hreadyout=0 OKAY, decrement; counter==0 -> hreadyout=1 OKAY,
//      complete; same edge may accept next address phase (-> DATA/ERR1) else -> IDLE.
//    ERR1: hreadyout=0 hresp=ERROR -> ERR2. ERR2: hreadyout=1 hresp=ERROR; new address accepted normally.
//  - Write: commits on completing edge of DATA using hwdata and latched strobes; errored beats never write.
//  - Read: hrdata = mem[latched word addr] (full word, all lanes) in DATA; 0 in IDLE/ERR1/ERR2.
//    With WAIT_STATES=0 read data returned the cycle after address phase (1-cycle latency).
//  - Write then read same word back-to-back: read returns newly written data (write commits first).
//  - Strobes (little-endian): byte -> 1<<haddr[1:0]; half -> 0011/1100 by haddr[1]; word -> 1111.
//  - Address phase presented while hready=0 is ignored. Reset mid-data-phase aborts beat, no write.
// STRUCTURE
//  - ahb_pkg: HTRANS_*, HRESP_*, HSIZE_* constants and FSM state encodings; shared with master/arbiter.
//  - Sub-module ahb_strb_gen: combinational (hsize, haddr[1:0]) -> 4-bit strobe + misalign flag.
//  - SRAM as reg array in this module, per-byte write enables.
// TESTING
//  1 Reset: assert hreset mid-write wait state -> hreadyout=1 hresp=00 hrdata=0 at once; word unchanged.
//  2 WAIT_STATES=0: word write 0x0000_0010=0xDEADBEEF, then read same addr back-to-back -> hreadyout
//    stays 1, hrdata=0xDEADBEEF in read data phase.
//  3 Byte write 0xAA to 0x11, half write 0x5566 to 0x12 over 0x11223344 -> word read =0x5566AA44.
//  4 WAIT_STATES=2: NONSEQ read -> hreadyout 0,0,1; hresp=00 throughout; data valid only on third cycle.
//  5 Word access at 0x02, then hsize=3, then addr 4*2**AW -> each: hreadyout 0 then 1 with hresp=01
//    both cycles; memory unchanged.
//  6 4-beat INCR write burst SEQ 0x20..0x2C with an IDLE and a !hsel cycle interleaved -> OKAY zero-wait
//    on IDLE/unselected; all four words written correctly.

Source files
------------

// File: rtl/ahb_pkg.sv
// Shared AHB-lite encodings (transfer type, response, size) and the SRAM responder FSM states.
package ahb_pkg;
    localparam logic [1:0] HTRANS_IDLE   = 2'b00;
    localparam logic [1:0] HTRANS_BUSY   = 2'b01;
    localparam logic [1:0] HTRANS_NONSEQ = 2'b10;
    localparam logic [1:0] HTRANS_SEQ    = 2'b11;

    localparam logic [1:0] HRESP_OKAY    = 2'b00;
    localparam logic [1:0] HRESP_ERROR   = 2'b01;

    localparam logic [2:0] HSIZE_BYTE    = 3'd0;
    localparam logic [2:0] HSIZE_HALF    = 3'd1;
    localparam logic [2:0] HSIZE_WORD    = 3'd2;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_DATA = 2'd1,
        ST_ERR1 = 2'd2,
        ST_ERR2 = 2'd3
    } slv_state_e;
endpackage

// File: rtl/ahb_strb_gen.sv
// Little-endian byte-lane strobes and alignment flag from transfer size and low address bits.
module ahb_strb_gen
    import ahb_pkg::*;
(
    input  logic [2:0] size_i,
    input  logic [1:0] addr_lo_i,
    output logic [3:0] strb_o,
    output logic       misalign_o
);
    always_comb begin
        strb_o     = 4'b0000;
        misalign_o = 1'b0;
        case (size_i)
            HSIZE_BYTE: strb_o = 4'b0001 << addr_lo_i;
            HSIZE_HALF: begin
                strb_o     = addr_lo_i[1] ? 4'b1100 : 4'b0011;
                misalign_o = addr_lo_i[0];
            end
            HSIZE_WORD: begin
                strb_o     = 4'b1111;
                misalign_o = |addr_lo_i;
            end
            default: ;
        endcase
    end
endmodule

// File: rtl/ahb_sram_slave.sv
// AHB responder over a word-addressed SRAM: pipelined address/data phase, programmable wait
// states, byte/half/word writes through lane strobes, two-cycle ERROR response.
module ahb_sram_slave
    import ahb_pkg::*;
#(
    parameter int AW          = 10,
    parameter int WAIT_STATES = 0
) (
    input  logic        hclk,
    input  logic        hreset,
    input  logic        hsel,
    input  logic [31:0] haddr,
    input  logic [1:0]  htrans,
    input  logic        hwrite,
    input  logic [2:0]  hsize,
    input  logic [2:0]  hburst,
    input  logic [3:0]  hprot,
    input  logic        hready,
    input  logic [31:0] hwdata,
    output logic        hreadyout,
    output logic [1:0]  hresp,
    output logic [31:0] hrdata
);
    localparam int         DEPTH = 1 << AW;
    localparam logic [3:0] WS    = 4'(WAIT_STATES);

    slv_state_e    state_q;
    logic [AW-1:0] waddr_q;
    logic [3:0]    strb_q;
    logic          write_q;
    logic [3:0]    cnt_q;
    logic          hreadyout_q;
    logic [1:0]    hresp_q;
    logic [31:0]   mem [DEPTH];

    logic [3:0]    strb;
    logic          misalign;
    logic          accept;
    logic          bad;
    logic          commit;
    logic          unused_bits;

    ahb_strb_gen u_strb_gen (
        .size_i     (hsize),
        .addr_lo_i  (haddr[1:0]),
        .strb_o     (strb),
        .misalign_o (misalign)
    );

    assign unused_bits = ^{hburst, hprot};

    assign accept = hsel & hready & htrans[1];
    assign bad    = (hsize > HSIZE_WORD) | misalign | (|(haddr >> (AW + 2)));
    assign commit = (state_q == ST_DATA) && (cnt_q == 4'd0) && write_q;

    // The wait counter stalls the bus, so acceptance only happens in IDLE, ERR2 or a completing DATA cycle.
    always_ff @(posedge hclk or posedge hreset) begin
        if (hreset) begin
            state_q     <= ST_IDLE;
            hreadyout_q <= 1'b1;
            hresp_q     <= HRESP_OKAY;
            cnt_q       <= 4'd0;
            waddr_q     <= '0;
            strb_q      <= 4'b0000;
            write_q     <= 1'b0;
        end else if (state_q == ST_ERR1) begin
            state_q     <= ST_ERR2;
            hreadyout_q <= 1'b1;
            hresp_q     <= HRESP_ERROR;
        end else if ((state_q == ST_DATA) && (cnt_q != 4'd0)) begin
            cnt_q       <= cnt_q - 4'd1;
            hreadyout_q <= (cnt_q == 4'd1);
        end else if (accept && bad) begin
            state_q     <= ST_ERR1;
            hreadyout_q <= 1'b0;
            hresp_q     <= HRESP_ERROR;
        end else if (accept) begin
            state_q     <= ST_DATA;
            cnt_q       <= WS;
            hreadyout_q <= (WS == 4'd0);
            hresp_q     <= HRESP_OKAY;
            waddr_q     <= haddr[AW+1:2];
            strb_q      <= strb;
            write_q     <= hwrite;
        end else begin
            state_q     <= ST_IDLE;
            hreadyout_q <= 1'b1;
            hresp_q     <= HRESP_OKAY;
        end
    end

    always_ff @(posedge hclk) begin
        if (commit) begin
            for (int b = 0; b < 4; b++) begin
                if (strb_q[b]) mem[waddr_q][8*b +: 8] <= hwdata[8*b +: 8];
            end
        end
    end

    // Writes land at the end of their data phase, so a following read sees them directly.
    assign hrdata    = (state_q == ST_DATA) ? mem[waddr_q] : 32'h0;
    assign hreadyout = hreadyout_q;
    assign hresp     = hresp_q;
endmodule

// File: tb/tb_ahb_sram_slave.sv
// Drives two responders (zero and two wait states) with directed and random AHB traffic against a byte-array model.
module tb_ahb_sram_slave;
    import ahb_pkg::*;

    localparam int AW = 6;
    localparam int NB = 4 << AW;

    logic        hclk = 1'b0;
    logic        hreset;
    logic        hsel0, hsel2, hwrite, hready, ds;
    logic [31:0] haddr, hwdata;
    logic [1:0]  htrans;
    logic [2:0]  hsize, hburst;
    logic [3:0]  hprot;
    logic        ro0, ro2;
    logic [1:0]  rs0, rs2;
    logic [31:0] rd0, rd2;

    typedef struct {
        bit        sel;
        bit [1:0]  trans;
        bit        wr;
        bit [2:0]  size;
        bit [31:0] addr;
        bit [31:0] wdata;
    } beat_t;

    beat_t    q[$];
    bit [7:0] mb [2][NB];
    int       n_chk  = 0;
    int       n_pass = 0;

    always #5 hclk = ~hclk;
    assign hready = ds ? ro2 : ro0;

    ahb_sram_slave #(.AW(AW), .WAIT_STATES(0)) dut0 (
        .hclk(hclk), .hreset(hreset), .hsel(hsel0), .haddr(haddr), .htrans(htrans),
        .hwrite(hwrite), .hsize(hsize), .hburst(hburst), .hprot(hprot), .hready(hready),
        .hwdata(hwdata), .hreadyout(ro0), .hresp(rs0), .hrdata(rd0)
    );

    ahb_sram_slave #(.AW(AW), .WAIT_STATES(2)) dut2 (
        .hclk(hclk), .hreset(hreset), .hsel(hsel2), .haddr(haddr), .htrans(htrans),
        .hwrite(hwrite), .hsize(hsize), .hburst(hburst), .hprot(hprot), .hready(hready),
        .hwdata(hwdata), .hreadyout(ro2), .hresp(rs2), .hrdata(rd2)
    );

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %h expected %h at %0t", tag, got, exp, $time);
    endtask

    function automatic void push(input bit sel, input bit [1:0] tr, input bit wr,
                                 input bit [2:0] sz, input bit [31:0] a, input bit [31:0] wd);
        beat_t b;
        b.sel = sel; b.trans = tr; b.wr = wr; b.size = sz; b.addr = a; b.wdata = wd;
        q.push_back(b);
    endfunction

    function automatic bit is_bad(input beat_t b);
        return (b.size > 3'd2) || (b.size == 3'd1 && b.addr[0]) ||
               (b.size == 3'd2 && b.addr[1:0] != 2'b00) || (b.addr >= 32'(NB));
    endfunction

    function automatic void model_write(input int d, input beat_t b);
        int n = 1 << b.size;
        for (int k = 0; k < n; k++) begin
            int a = int'(b.addr) + k;
            mb[d][a] = b.wdata[8*(a%4) +: 8];
        end
    endfunction

    function automatic logic [31:0] model_word(input int d, input bit [31:0] addr);
        int base = int'(addr) & ~3;
        return {mb[d][base+3], mb[d][base+2], mb[d][base+1], mb[d][base]};
    endfunction

    // Plays the queued address phases as a pipelined master and checks every cycle's response.
    task automatic run(input int d);
        beat_t       cur, dp;
        bit          have_dp = 1'b0;
        bit          bad_dp  = 1'b0;
        int          cyc     = 0;
        int          guard   = 0;
        int          ws      = (d != 0) ? 2 : 0;
        logic        r;
        logic [1:0]  rsp;
        logic [31:0] rd;
        ds = (d != 0);
        while (q.size() > 0 || have_dp) begin
            if (q.size() > 0) cur = q[0];
            else begin
                cur.sel = 1'b0; cur.trans = HTRANS_IDLE; cur.wr = 1'b0;
                cur.size = 3'd0; cur.addr = 32'h0; cur.wdata = 32'h0;
            end
            hsel0  = cur.sel && (d == 0);
            hsel2  = cur.sel && (d != 0);
            htrans = cur.trans;
            hwrite = cur.wr;
            hsize  = cur.size;
            haddr  = cur.addr;
            hburst = 3'($urandom);
            hprot  = 4'($urandom);
            hwdata = have_dp ? dp.wdata : $urandom;
            @(negedge hclk);
            r   = (d != 0) ? ro2 : ro0;
            rsp = (d != 0) ? rs2 : rs0;
            rd  = (d != 0) ? rd2 : rd0;
            if (!have_dp) begin
                chk("idle_rdy", 32'(r), 32'd1);
                chk("idle_resp", 32'(rsp), 32'(HRESP_OKAY));
                chk("idle_rdata", rd, 32'h0);
            end else if (bad_dp) begin
                chk("err_rdy", 32'(r), (cyc == 0) ? 32'd0 : 32'd1);
                chk("err_resp", 32'(rsp), 32'(HRESP_ERROR));
                chk("err_rdata", rd, 32'h0);
            end else begin
                chk("ok_rdy", 32'(r), (cyc >= ws) ? 32'd1 : 32'd0);
                chk("ok_resp", 32'(rsp), 32'(HRESP_OKAY));
                if (!dp.wr && cyc >= ws) chk("rdata", rd, model_word(d, dp.addr));
            end
            @(posedge hclk);
            if (r) begin
                if (have_dp && !bad_dp && dp.wr) model_write(d, dp);
                have_dp = 1'b0;
                if (q.size() > 0) begin
                    cur = q.pop_front();
                    if (cur.sel && cur.trans[1]) begin
                        dp = cur; have_dp = 1'b1; bad_dp = is_bad(cur); cyc = 0;
                    end
                end
            end else begin
                cyc++;
            end
            #1;
            guard++;
            if (guard > 4000) begin
                chk("timeout_cycles", 32'(guard), 32'd4000);
                q.delete();
                have_dp = 1'b0;
            end
        end
        hsel0 = 1'b0; hsel2 = 1'b0; htrans = HTRANS_IDLE;
    endtask

    initial begin
        beat_t b;
        hreset = 1'b1; ds = 1'b0; hsel0 = 1'b0; hsel2 = 1'b0; htrans = HTRANS_IDLE;
        hwrite = 1'b0; hsize = HSIZE_WORD; haddr = 32'h0; hwdata = 32'h0; hburst = 3'd0; hprot = 4'd0;
        #12;
        chk("rst0_rdy", 32'(ro0), 32'd1);
        chk("rst0_resp", 32'(rs0), 32'd0);
        chk("rst0_rdata", rd0, 32'h0);
        chk("rst2_rdy", 32'(ro2), 32'd1);
        chk("rst2_resp", 32'(rs2), 32'd0);
        chk("rst2_rdata", rd2, 32'h0);
        @(posedge hclk); #1 hreset = 1'b0;

        for (int d = 0; d < 2; d++) begin
            for (int w = 0; w < NB / 4; w++) push(1, HTRANS_NONSEQ, 1, HSIZE_WORD, 32'(4 * w), $urandom);
            run(d);
        end

        // Back-to-back write then read of the same word, then sub-word merge.
        push(1, HTRANS_NONSEQ, 1, HSIZE_WORD, 32'h10, 32'hDEADBEEF);
        push(1, HTRANS_NONSEQ, 0, HSIZE_WORD, 32'h10, 32'h0);
        push(1, HTRANS_NONSEQ, 1, HSIZE_WORD, 32'h10, 32'h11223344);
        push(1, HTRANS_NONSEQ, 1, HSIZE_BYTE, 32'h11, 32'h0000AA00);
        push(1, HTRANS_NONSEQ, 1, HSIZE_HALF, 32'h12, 32'h55660000);
        push(1, HTRANS_NONSEQ, 0, HSIZE_WORD, 32'h10, 32'h0);
        run(0);
        push(1, HTRANS_NONSEQ, 0, HSIZE_WORD, 32'h10, 32'h0);
        run(1);

        // Error beats on both responders, then burst with idle/unselected gaps.
        for (int d = 0; d < 2; d++) begin
            push(1, HTRANS_NONSEQ, 1, HSIZE_WORD, 32'h02, 32'hFFFFFFFF);
            push(1, HTRANS_NONSEQ, 1, 3'd3, 32'h00, 32'hFFFFFFFF);
            push(1, HTRANS_NONSEQ, 1, HSIZE_WORD, 32'(NB), 32'hFFFFFFFF);
            push(1, HTRANS_NONSEQ, 1, HSIZE_HALF, 32'h05, 32'hFFFFFFFF);
            push(1, HTRANS_NONSEQ, 0, HSIZE_WORD, 32'h00, 32'h0);
            push(1, HTRANS_NONSEQ, 1, HSIZE_WORD, 32'h20, 32'hA0A0A0A0);
            push(1, HTRANS_SEQ,    1, HSIZE_WORD, 32'h24, 32'hB1B1B1B1);
            push(1, HTRANS_IDLE,   0, HSIZE_WORD, 32'h28, 32'h0);
            push(1, HTRANS_SEQ,    1, HSIZE_WORD, 32'h28, 32'hC2C2C2C2);
            push(0, HTRANS_NONSEQ, 0, HSIZE_WORD, 32'h2C, 32'h0);
            push(1, HTRANS_SEQ,    1, HSIZE_WORD, 32'h2C, 32'hD3D3D3D3);
            for (int w = 0; w < 4; w++) push(1, HTRANS_NONSEQ, 0, HSIZE_WORD, 32'(32 + 4 * w), 32'h0);
            run(d);
        end

        // Reset during a write wait state: outputs recover immediately and the word is untouched.
        ds = 1'b1; hsel2 = 1'b1; htrans = HTRANS_NONSEQ; hwrite = 1'b1; hsize = HSIZE_WORD; haddr = 32'h40;
        @(posedge hclk); #1;
        hsel2 = 1'b0; htrans = HTRANS_IDLE; hwdata = 32'h12345678;
        @(negedge hclk);
        chk("rst_pre_rdy", 32'(ro2), 32'd0);
        #2 hreset = 1'b1;
        #1;
        chk("rst_mid_rdy", 32'(ro2), 32'd1);
        chk("rst_mid_resp", 32'(rs2), 32'd0);
        chk("rst_mid_rdata", rd2, 32'h0);
        @(posedge hclk); #1 hreset = 1'b0;
        push(1, HTRANS_NONSEQ, 0, HSIZE_WORD, 32'h40, 32'h0);
        run(1);

        for (int d = 0; d < 2; d++) begin
            for (int i = 0; i < 250; i++) begin
                b.sel   = ($urandom_range(9) != 0);
                b.trans = 2'($urandom_range(3));
                if ($urandom_range(3) != 0) b.trans[1] = 1'b1;
                b.wr    = 1'($urandom);
                b.size  = ($urandom_range(15) == 0) ? 3'($urandom_range(7, 3)) : 3'($urandom_range(2));
                b.addr  = ($urandom_range(1) != 0) ? 32'($urandom_range(15)) : 32'($urandom_range(NB - 1));
                if ($urandom_range(7) != 0 && b.size <= 3'd2) b.addr = b.addr & ~((32'd1 << b.size) - 32'd1);
                if ($urandom_range(19) == 0) b.addr = b.addr | (32'd1 << $urandom_range(31, AW + 2));
                b.wdata = $urandom;
                q.push_back(b);
            end
            run(d);
        end

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end
endmodule
